// File: rtl/l2req_arb.sv
// Generic synchronous FIFO with registered occupancy count and head read straight from storage.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the owner must not push when full or pop when empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [W-1:0]               head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately unreset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// Arbitrates DC (fixed priority) and IC onto the L2 request channel, bounding IC starvation.
// Latency: one cycle from input acceptance to l1tol2_req_valid; no bypass path.
// Backpressure: input retries depend only on the registered FIFO count, never on l1tol2_req_retry.
module l2req_arb #(
    parameter int REQ_W      = 64,
    parameter int STARVE_LIM = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dc_req_valid,
    output logic             dc_req_retry,
    input  logic [REQ_W-1:0] dc_req,
    input  logic             ic_req_valid,
    output logic             ic_req_retry,
    input  logic [REQ_W-1:0] ic_req,
    output logic             l1tol2_req_valid,
    input  logic             l1tol2_req_retry,
    output logic [REQ_W-1:0] l1tol2_req,
    output logic             l1tol2_req_src
);
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef struct packed {
        logic             src;
        logic [REQ_W-1:0] payload;
    } entry_t;

    logic [1:0]    count;
    logic [SW-1:0] starve_cnt;
    logic          space;
    logic          ic_wins;
    logic          grant_dc;
    logic          grant_ic;
    logic          push;
    logic          pop;
    entry_t        push_ent;
    entry_t        head_ent;

    always_comb begin
        space    = (count < 2'd2);
        ic_wins  = ic_req_valid && (!dc_req_valid || (starve_cnt == SW'(STARVE_LIM)));
        // Reset gates grants so both retries read 1 for the whole time reset is held.
        grant_ic = space && !reset && ic_wins;
        grant_dc = space && !reset && dc_req_valid && !ic_wins;
        push     = grant_dc || grant_ic;

        push_ent.src     = grant_ic;
        push_ent.payload = grant_ic ? ic_req : dc_req;

        dc_req_retry     = !grant_dc;
        ic_req_retry     = !grant_ic;
        l1tol2_req_valid = (count != 2'd0);
        pop              = l1tol2_req_valid && !l1tol2_req_retry;
        l1tol2_req       = head_ent.payload;
        l1tol2_req_src   = head_ent.src;
    end

    // Counts DC wins while IC waits; a withdrawn IC request forfeits its accumulated claim.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!ic_req_valid || grant_ic) begin
            starve_cnt <= '0;
        end else if (grant_dc && (starve_cnt != SW'(STARVE_LIM))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    sync_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (2)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .count    (count),
        .head_dat (head_ent)
    );

endmodule

// File: tb/tb_l2req_arb.sv
// Scoreboard bench for l2req_arb: tests queue expected {src, payload} at grant, the monitor checks each pop.
module tb_l2req_arb;
    localparam int REQ_W      = 64;
    localparam int STARVE_LIM = 3;

    typedef struct packed {
        logic             src;
        logic [REQ_W-1:0] payload;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             dc_req_valid;
    logic             dc_req_retry;
    logic [REQ_W-1:0] dc_req;
    logic             ic_req_valid;
    logic             ic_req_retry;
    logic [REQ_W-1:0] ic_req;
    logic             l1tol2_req_valid;
    logic             l1tol2_req_retry;
    logic [REQ_W-1:0] l1tol2_req;
    logic             l1tol2_req_src;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    l2req_arb #(
        .REQ_W      (REQ_W),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .dc_req_valid     (dc_req_valid),
        .dc_req_retry     (dc_req_retry),
        .dc_req           (dc_req),
        .ic_req_valid     (ic_req_valid),
        .ic_req_retry     (ic_req_retry),
        .ic_req           (ic_req),
        .l1tol2_req_valid (l1tol2_req_valid),
        .l1tol2_req_retry (l1tol2_req_retry),
        .l1tol2_req       (l1tol2_req),
        .l1tol2_req_src   (l1tol2_req_src)
    );

    // Inputs change at posedge+2 and are stable here, so a transfer seen now happens at the next posedge.
    always @(negedge clk) begin
        if (!reset && l1tol2_req_valid && !l1tol2_req_retry) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got src=%0d dat=%h, required no output", l1tol2_req_src, l1tol2_req);
            end else begin
                mon_e = exp_q.pop_front();
                if ({l1tol2_req_src, l1tol2_req} !== mon_e) begin
                    n_err++;
                    $display("FAIL sb_pop: got src=%0d dat=%h, required src=%0d dat=%h",
                             l1tol2_req_src, l1tol2_req, mon_e.src, mon_e.payload);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        next_cycle();
        dc_req_valid     = 1'b0;
        ic_req_valid     = 1'b0;
        l1tol2_req_retry = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            sample();
        end
        next_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dc_req_valid = 1'b1; dc_req = 64'hDEAD_0001;
        ic_req_valid = 1'b1; ic_req = 64'hBEEF_0001;
        l1tol2_req_retry = 1'b0;
        sample();
        n_vec++;
        if ({l1tol2_req_valid, dc_req_retry, ic_req_retry} !== 3'b011) begin
            n_err++;
            $display("FAIL rst_hold: got valid/dcr/icr=%b, required 011",
                     {l1tol2_req_valid, dc_req_retry, ic_req_retry});
        end

        next_cycle();
        reset = 1'b0;
        l1tol2_req_retry = 1'b1;
        dc_req_valid = 1'b1; dc_req = 64'hD0A0;
        ic_req_valid = 1'b0;
        sample();
        n_vec++;
        if (dc_req_retry !== 1'b0) begin
            n_err++; $display("FAIL rst_fill_dc: got dc_retry=%b, required 0", dc_req_retry);
        end
        exp_q.push_back({1'b0, dc_req});

        next_cycle();
        dc_req_valid = 1'b0;
        ic_req_valid = 1'b1; ic_req = 64'hA0A0;
        sample();
        n_vec++;
        if (ic_req_retry !== 1'b0) begin
            n_err++; $display("FAIL rst_fill_ic: got ic_retry=%b, required 0", ic_req_retry);
        end
        exp_q.push_back({1'b1, ic_req});

        next_cycle();
        dc_req_valid = 1'b1; dc_req = 64'hD0A1;
        ic_req_valid = 1'b1; ic_req = 64'hA0A1;
        sample();
        n_vec++;
        if ({l1tol2_req_valid, dc_req_retry, ic_req_retry} !== 3'b111) begin
            n_err++;
            $display("FAIL rst_full: got valid/dcr/icr=%b, required 111",
                     {l1tol2_req_valid, dc_req_retry, ic_req_retry});
        end

        // Mid-cycle reset with the FIFO full: output valid must drop without waiting for an edge.
        #1 reset = 1'b1;
        #1;
        exp_q.delete();
        n_vec++;
        if ({l1tol2_req_valid, dc_req_retry, ic_req_retry} !== 3'b011) begin
            n_err++;
            $display("FAIL rst_async: got valid/dcr/icr=%b, required 011",
                     {l1tol2_req_valid, dc_req_retry, ic_req_retry});
        end

        next_cycle();
        reset = 1'b0;
        dc_req_valid = 1'b1; dc_req = 64'hD0C0;
        ic_req_valid = 1'b0;
        sample();
        n_vec++;
        if ({l1tol2_req_valid, dc_req_retry} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_restart_dc: got valid/dcr=%b, required 00", {l1tol2_req_valid, dc_req_retry});
        end
        exp_q.push_back({1'b0, dc_req});

        next_cycle();
        dc_req_valid = 1'b0;
        ic_req_valid = 1'b1; ic_req = 64'hA0C0;
        sample();
        n_vec++;
        if ({ic_req_retry, l1tol2_req_valid, l1tol2_req_src, l1tol2_req} !== {1'b0, 1'b1, 1'b0, 64'hD0C0}) begin
            n_err++;
            $display("FAIL rst_restart_ic: got icr=%b valid=%b src=%0d dat=%h, required icr=0 valid=1 src=0 dat=d0c0",
                     ic_req_retry, l1tol2_req_valid, l1tol2_req_src, l1tol2_req);
        end
        exp_q.push_back({1'b1, ic_req});

        next_cycle();
        dc_req_valid = 1'b1; dc_req = 64'hD0C1;
        ic_req_valid = 1'b1; ic_req = 64'hA0C1;
        sample();
        n_vec++;
        if ({dc_req_retry, ic_req_retry} !== 2'b11) begin
            n_err++;
            $display("FAIL rst_refull: got dcr/icr=%b, required 11", {dc_req_retry, ic_req_retry});
        end

        drain();
        n_vec++;
        if (exp_q.size() != 0 || l1tol2_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_drain: got left=%0d valid=%b, required left=0 valid=0", exp_q.size(), l1tol2_req_valid);
        end
    endtask

    task automatic test_ic_only();
        next_cycle();
        ic_req_valid = 1'b1; ic_req = 64'hABCD;
        dc_req_valid = 1'b0;
        l1tol2_req_retry = 1'b0;
        sample();
        n_vec++;
        if ({ic_req_retry, dc_req_retry, l1tol2_req_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL ic_accept: got icr/dcr/valid=%b, required 010",
                     {ic_req_retry, dc_req_retry, l1tol2_req_valid});
        end
        exp_q.push_back({1'b1, 64'hABCD});

        next_cycle();
        ic_req_valid = 1'b0;
        sample();
        n_vec++;
        if ({l1tol2_req_valid, l1tol2_req_src, l1tol2_req} !== {1'b1, 1'b1, 64'hABCD}) begin
            n_err++;
            $display("FAIL ic_latency: got valid=%b src=%0d dat=%h, required valid=1 src=1 dat=abcd",
                     l1tol2_req_valid, l1tol2_req_src, l1tol2_req);
        end

        drain();
        n_vec++;
        if (exp_q.size() != 0 || l1tol2_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ic_drain: got left=%0d valid=%b, required 0/0", exp_q.size(), l1tol2_req_valid);
        end
    endtask

    task automatic test_starvation();
        logic [7:0]       src_seq;
        logic [REQ_W-1:0] dpay;
        logic [REQ_W-1:0] ipay;
        src_seq = 8'b1000_1000;
        dpay = 64'h1000;
        ipay = 64'h2000;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            dc_req_valid = 1'b1; dc_req = dpay;
            ic_req_valid = 1'b1; ic_req = ipay;
            l1tol2_req_retry = 1'b0;
            sample();
            n_vec++;
            if ({dc_req_retry, ic_req_retry} !== {src_seq[i], ~src_seq[i]}) begin
                n_err++;
                $display("FAIL starve_grant[%0d]: got dcr/icr=%b, required %b",
                         i, {dc_req_retry, ic_req_retry}, {src_seq[i], ~src_seq[i]});
            end
            exp_q.push_back({src_seq[i], src_seq[i] ? ipay : dpay});
            if (src_seq[i]) ipay = ipay + 1;
            else            dpay = dpay + 1;
        end
        drain();
        n_vec++;
        if (exp_q.size() != 0 || l1tol2_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL starve_drain: got left=%0d valid=%b, required 0/0", exp_q.size(), l1tol2_req_valid);
        end
    endtask

    task automatic test_full_order();
        next_cycle();
        l1tol2_req_retry = 1'b1;
        dc_req_valid = 1'b1; dc_req = 64'hD1;
        ic_req_valid = 1'b0;
        sample();
        n_vec++;
        if (dc_req_retry !== 1'b0) begin
            n_err++; $display("FAIL full_d1: got dc_retry=%b, required 0", dc_req_retry);
        end
        exp_q.push_back({1'b0, 64'hD1});

        next_cycle();
        dc_req_valid = 1'b0;
        ic_req_valid = 1'b1; ic_req = 64'hE1;
        sample();
        n_vec++;
        if (ic_req_retry !== 1'b0) begin
            n_err++; $display("FAIL full_i1: got ic_retry=%b, required 0", ic_req_retry);
        end
        exp_q.push_back({1'b1, 64'hE1});

        for (int i = 0; i < 3; i++) begin
            next_cycle();
            dc_req_valid = 1'b1; dc_req = 64'hD2;
            ic_req_valid = 1'b1; ic_req = 64'hE2;
            sample();
            n_vec++;
            if ({dc_req_retry, ic_req_retry, l1tol2_req_valid, l1tol2_req_src, l1tol2_req} !==
                {1'b1, 1'b1, 1'b1, 1'b0, 64'hD1}) begin
                n_err++;
                $display("FAIL full_hold[%0d]: got dcr=%b icr=%b valid=%b src=%0d dat=%h, required 1 1 1 0 d1",
                         i, dc_req_retry, ic_req_retry, l1tol2_req_valid, l1tol2_req_src, l1tol2_req);
            end
        end

        drain();
        n_vec++;
        if (exp_q.size() != 0 || l1tol2_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_drain: got left=%0d valid=%b, required 0/0", exp_q.size(), l1tol2_req_valid);
        end
    endtask

    task automatic test_full_pop();
        next_cycle();
        l1tol2_req_retry = 1'b1;
        dc_req_valid = 1'b1; dc_req = 64'h51;
        ic_req_valid = 1'b0;
        sample();
        exp_q.push_back({1'b0, 64'h51});

        next_cycle();
        dc_req = 64'h52;
        sample();
        n_vec++;
        if (dc_req_retry !== 1'b0) begin
            n_err++; $display("FAIL fpop_fill: got dc_retry=%b, required 0", dc_req_retry);
        end
        exp_q.push_back({1'b0, 64'h52});

        // Full FIFO popping this cycle must still refuse the push.
        next_cycle();
        dc_req = 64'h53;
        l1tol2_req_retry = 1'b0;
        sample();
        n_vec++;
        if ({dc_req_retry, l1tol2_req_valid} !== 2'b11) begin
            n_err++;
            $display("FAIL fpop_noreuse: got dcr/valid=%b, required 11", {dc_req_retry, l1tol2_req_valid});
        end

        next_cycle();
        l1tol2_req_retry = 1'b1;
        sample();
        n_vec++;
        if (dc_req_retry !== 1'b0) begin
            n_err++; $display("FAIL fpop_accept: got dc_retry=%b, required 0", dc_req_retry);
        end
        exp_q.push_back({1'b0, 64'h53});

        next_cycle();
        dc_req_valid = 1'b0;
        ic_req_valid = 1'b1; ic_req = 64'h59;
        sample();
        n_vec++;
        if ({ic_req_retry, l1tol2_req_valid, l1tol2_req} !== {1'b1, 1'b1, 64'h52}) begin
            n_err++;
            $display("FAIL fpop_refull: got icr=%b valid=%b dat=%h, required icr=1 valid=1 dat=52",
                     ic_req_retry, l1tol2_req_valid, l1tol2_req);
        end

        drain();
        n_vec++;
        if (exp_q.size() != 0 || l1tol2_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fpop_drain: got left=%0d valid=%b, required 0/0", exp_q.size(), l1tol2_req_valid);
        end
    endtask

    task automatic test_starve_clear();
        logic [6:0]       src_seq;
        logic [6:0]       ic_pat;
        logic [REQ_W-1:0] dpay;
        logic [REQ_W-1:0] ipay;
        src_seq = 7'b100_0000;
        ic_pat  = 7'b111_1011;
        dpay = 64'h3000;
        ipay = 64'h4000;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            dc_req_valid = 1'b1; dc_req = dpay;
            ic_req_valid = ic_pat[i]; ic_req = ipay;
            l1tol2_req_retry = 1'b0;
            sample();
            n_vec++;
            if ({dc_req_retry, ic_req_retry} !== {src_seq[i], ~src_seq[i]}) begin
                n_err++;
                $display("FAIL sclr_grant[%0d]: got dcr/icr=%b, required %b",
                         i, {dc_req_retry, ic_req_retry}, {src_seq[i], ~src_seq[i]});
            end
            exp_q.push_back({src_seq[i], src_seq[i] ? ipay : dpay});
            if (src_seq[i]) ipay = ipay + 1;
            else            dpay = dpay + 1;
        end
        drain();
        n_vec++;
        if (exp_q.size() != 0 || l1tol2_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sclr_drain: got left=%0d valid=%b, required 0/0", exp_q.size(), l1tol2_req_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        dc_req_valid = 1'b0; dc_req = '0;
        ic_req_valid = 1'b0; ic_req = '0;
        l1tol2_req_retry = 1'b0;
        test_reset();
        test_ic_only();
        test_starvation();
        test_full_order();
        test_full_pop();
        test_starve_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l2req_arb.md
Name: l2req_arb

Overview:
- Shares the single L1-to-L2 request channel between the data cache (DC, requester 0) and the instruction cache (IC, requester 1).
- DC has fixed priority. A starvation counter bounds how long IC can wait.
- Granted requests go into a 2-entry output FIFO, so neither input retry depends combinationally on the downstream retry.
- Sits between the L1 caches and the l2cache_pipe request port. Each entry is tagged with its source so L2 responses can be routed back.

Parameters:
- REQ_W, 64: width of the request payload in bits.
- STARVE_LIM, 3: maximum consecutive DC grants while IC is waiting; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- dc_req_valid  in  1  DC request valid.
- dc_req_retry  out  1  DC request not accepted this cycle.
- dc_req  in  REQ_W  DC request payload.
- ic_req_valid  in  1  IC request valid.
- ic_req_retry  out  1  IC request not accepted this cycle.
- ic_req  in  REQ_W  IC request payload.
- l1tol2_req_valid  out  1  FIFO head valid.
- l1tol2_req_retry  in  1  L2 cannot accept the head this cycle.
- l1tol2_req  out  REQ_W  FIFO head payload.
- l1tol2_req_src  out  1  head source: 0 = DC, 1 = IC.

Behaviour:
- Handshake (all channels): transfer occurs in a cycle where valid=1 and retry=0. A requester holds valid and payload stable until transferred.
- Reset (asynchronous): count=0, starve_cnt=0, FIFO pointers=0. While reset is asserted: l1tol2_req_valid=0, dc_req_retry=1, ic_req_retry=1. FIFO contents are discarded, including mid-transfer ones.
- FIFO:
  - 2 entries of {src, payload}; count is 0..2 and registered.
  - space = (count < 2), evaluated from registered count only.
  - pop = l1tol2_req_valid & ~l1tol2_req_retry.
  - When count==2 and a pop occurs, no push occurs that cycle (no same-cycle reuse of a full slot).
  - When count is 0 or 1, push and pop may occur in the same cycle; count is unchanged and order is preserved.
- Outputs:
  - l1tol2_req_valid = (count != 0).
  - l1tol2_req and l1tol2_req_src come from the head entry.
  - Latency: an accepted request appears at the output the next cycle when the FIFO was empty. Minimum 1 cycle, no bypass.
- Grant (combinational from inputs, count and starve_cnt), evaluated only when space=1:
  - Only DC valid: grant DC.
  - Only IC valid: grant IC.
  - Both valid and starve_cnt == STARVE_LIM: grant IC.
  - Both valid otherwise: grant DC.
  - Granted input: retry=0 and its entry is pushed.
  - Non-granted input and all inputs when space=0: retry=1.
  - At most one push per cycle.
- Starvation counter: width clog2(STARVE_LIM+1), saturates at STARVE_LIM.
  - DC granted and IC valid: starve_cnt+1.
  - IC granted: cleared to 0.
  - IC not valid: cleared to 0.
  - space=0 and IC valid: hold.
- Boundary conditions:
  - Downstream retry held indefinitely: FIFO fills to 2, both inputs see retry=1, contents and order are held.
  - Payload of a retried input is never captured.
  - A requester withdrawing valid is tolerated; no state other than starve_cnt depends on it.

Test Plan:
1. Reset with count=2, assert reset mid-cycle -> l1tol2_req_valid=0 immediately. After release, both retries=0 when a requester is valid, and count restarts from 0.
2. Only IC valid, payload 0xABCD, l1tol2_req_retry=0 -> ic_req_retry=0 in cycle N. Cycle N+1: l1tol2_req_valid=1, l1tol2_req=0xABCD, src=1.
3. Both valid every cycle, STARVE_LIM=3, no downstream retry, new payload after each transfer -> output src sequence 0,0,0,1,0,0,0,1.
4. l1tol2_req_retry=1, DC pushes D1 then IC pushes I1 -> count=2 and both retries=1. Release retry -> pops D1 then I1 in order.
5. count=2 with DC valid, pop in cycle N -> dc_req_retry=1 in cycle N. DC accepted in N+1, which ends with count=2 again.
6. DC granted twice while IC valid (starve_cnt=2), then IC drops valid for one cycle and reasserts -> starve_cnt=0. Three more DC grants are required before IC wins.
